spi_bridge_sync: RTL and testbench
==================================

Name: spi_bridge_sync

Overview:
- Parametrised SPI slave bridge, fully synchronous to the peripheral clock `clk`.
- `sclk`, `cs_n` and `mosi` are oversampled through synchronisers; edges are detected in the `clk` domain.
- Supports any word width and all four SPI modes (CPOL/CPHA).
- Sits between the external SPI master and the register/PWM control logic:
  - delivers each received word with a one-cycle valid strobe;
  - captures the next transmit word through a request/response timing contract.

Parameters:
- DATA_W, 8, bits per SPI word (4..32).
- CPOL, 0, idle level of sclk (0 = idle low, 1 = idle high).
- CPHA, 0, 0 = sample on leading edge and shift on trailing edge; 1 = shift on leading edge and sample on trailing edge.
- SYNC_STAGES, 2, flip-flop stages on each of sclk, cs_n and mosi (2..3).

Ports:
- clk  input  1  peripheral clock; all logic on its rising edge.
- rst  input  1  reset; asynchronous, active-high.
- sclk  input  1  SPI clock from master (asynchronous).
- cs_n  input  1  chip select, active low (asynchronous).
- mosi  input  1  master-out data (asynchronous).
- miso  output  1  slave-out data, MSB first.
- miso_oe  output  1  1 while the synchronised cs_n is low; used for the external tristate.
- rx_data  output  DATA_W  last complete received word.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- tx_req  output  1  one-cycle pulse requesting the next transmit word.
- tx_data  input  DATA_W  transmit word; must be stable on the cycle after tx_req.
- busy  output  1  1 while cs_n is low (synchronised).

Behaviour:
- Reset values: miso=0, miso_oe=0, rx_data=0, rx_valid=0, tx_req=0, busy=0.
  - Reset clears bit counter, shift registers, synchronisers (to cs_n=1, sclk=CPOL) and the first-edge flag.
- Synchronisers: SYNC_STAGES flops per input, plus one history flop on sclk and cs_n for edge detection.
  - Input-to-detect latency: SYNC_STAGES+1 clk.
  - Required clk/sclk ratio: at least 8.
- Edge selection:
  - leading edge = rising if CPOL=0, falling if CPOL=1;
  - sample_edge = leading if CPHA=0, else trailing;
  - shift_edge = the other edge.
  - Edges are ignored while synchronised cs_n is high.
- States: IDLE (cs high), ACTIVE (cs low).
- IDLE -> ACTIVE on detected cs_n fall:
  - tx_req pulses on the same cycle;
  - tx_data is loaded into tx_shift on the next cycle;
  - bit_cnt=0; first-edge flag set.
- sample_edge in ACTIVE:
  - rx_shift <= {rx_shift[DATA_W-2:0], mosi_sync};
  - bit_cnt increments.
  - When bit_cnt == DATA_W-1 (modulo wrap):
    - bit_cnt <= 0;
    - on the next cycle rx_data <= completed word and rx_valid=1 for exactly one cycle;
    - tx_req pulses together with rx_valid;
    - tx_data is loaded into tx_shift one cycle after tx_req.
- shift_edge in ACTIVE: tx_shift <= {tx_shift[DATA_W-2:0], 1'b0}.
  - Exception, CPHA=1: the first shift_edge after each word load is suppressed (first-edge flag cleared instead), so the MSB stays on miso for the first bit.
- miso = tx_shift[DATA_W-1] while ACTIVE, else 0.
  - CPHA=0: MSB is valid before the first sample edge because of the load at cs fall.
- ACTIVE -> IDLE on detected cs_n rise:
  - partial word discarded, no rx_valid;
  - bit_cnt=0; tx_shift cleared; miso_oe=0 the same cycle.
- Simultaneous cs_n rise and sample edge in one clk: cs_n rise wins and the edge is dropped.
- Back-to-back words in one frame: the counter wraps and reception continues seamlessly, one rx_valid per DATA_W bits.
- rx_data holds its value until the next complete word.

Optional Feature:
- Macro SPI_BRIDGE_SYNC_FRAME_ERR_EN.
- Defined:
  - extra output frame_err (1 bit, reset 0);
  - pulses for one cycle on cs_n rise when bit_cnt != 0;
  - adds a sticky err_cnt output (8 bits, saturating at 255, cleared only by rst) counting such aborts.
- Undefined: neither port exists; aborted words are silently discarded.

Test Plan:
- Reset, then CPOL=0/CPHA=0, DATA_W=8: master sends 0xA5 with tx_data=0x3C -> rx_data=0xA5, one rx_valid pulse; master reads 0x3C on miso.
- CPHA=1, CPOL=1: two back-to-back words 0x12, 0xF0 in one cs frame, tx_data changed to 0x81 after the first tx_req -> rx_valid twice with 0x12 then 0xF0; miso returns the first word then 0x81.
- DATA_W=16: word 0xBEEF -> rx_data=0xBEEF, bit counter wraps at 16; no rx_valid after 8 bits.
- cs_n deasserted after 5 bits of 0xFF -> no rx_valid; rx_data keeps its previous value; miso_oe drops.
  - With SPI_BRIDGE_SYNC_FRAME_ERR_EN: frame_err pulses once and err_cnt=1.
- rst asserted mid-word (bit 3) -> all outputs 0 immediately; next full frame 0x5A received correctly.
- cs_n rise and final sample edge landing in the same clk -> word dropped, no rx_valid.

Source files
------------

// File: rtl/spi_bridge_sync.sv
// SPI slave bridge oversampled into the clk domain; supports all CPOL/CPHA modes and any DATA_W.
// Optional abort reporting (frame_err, err_cnt) is enabled by `SPI_BRIDGE_SYNC_FRAME_ERR_EN.
module spi_bridge_sync #(
  parameter int DATA_W      = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_req,
  input  logic [DATA_W-1:0] tx_data,
`ifdef SPI_BRIDGE_SYNC_FRAME_ERR_EN
  output logic              busy,
  output logic              frame_err,
  output logic [7:0]        err_cnt
`else
  output logic              busy
`endif
);

  localparam int               CNT_W     = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic             SCLK_IDLE = (CPOL != 0) ? 1'b1 : 1'b0;
  localparam logic             CPHA_B    = (CPHA != 0) ? 1'b1 : 1'b0;

  typedef enum logic [0:0] {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_r, cs_sync_r, mosi_sync_r;
  logic                   sclk_hist_r, cs_hist_r;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise_s, sclk_fall_s, lead_s, trail_s;
  logic                   sample_s, shift_s, cs_fall_s, cs_rise_s;

  state_t                 state_r;
  logic [CNT_W-1:0]       bit_cnt_r;
  logic [DATA_W-2:0]      rx_shift_r;
  logic [DATA_W-1:0]      tx_shift_r;
  logic                   first_edge_r;
  logic                   load_pend_r;

  assign sclk_s = sclk_sync_r[SYNC_STAGES-1];
  assign cs_s   = cs_sync_r[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_r[SYNC_STAGES-1];
  assign miso   = tx_shift_r[DATA_W-1];

  // Synchroniser chains plus one history stage on sclk and cs_n for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_r <= {SYNC_STAGES{SCLK_IDLE}};
      cs_sync_r   <= {SYNC_STAGES{1'b1}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      sclk_hist_r <= SCLK_IDLE;
      cs_hist_r   <= 1'b1;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], cs_n};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
      sclk_hist_r <= sclk_s;
      cs_hist_r   <= cs_s;
    end
  end

  // Map raw sclk edges onto sample/shift roles for the selected SPI mode
  always_comb begin
    sclk_rise_s = sclk_s & ~sclk_hist_r;
    sclk_fall_s = ~sclk_s & sclk_hist_r;
    cs_fall_s   = ~cs_s & cs_hist_r;
    cs_rise_s   = cs_s & ~cs_hist_r;
    if (CPOL != 0) begin
      lead_s  = sclk_fall_s;
      trail_s = sclk_rise_s;
    end else begin
      lead_s  = sclk_rise_s;
      trail_s = sclk_fall_s;
    end
    if (CPHA != 0) begin
      sample_s = trail_s;
      shift_s  = lead_s;
    end else begin
      sample_s = lead_s;
      shift_s  = trail_s;
    end
  end

  // Frame FSM; the first shift edge after a mid-frame reload is swallowed so the new MSB stays on miso
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      bit_cnt_r    <= '0;
      rx_shift_r   <= '0;
      tx_shift_r   <= '0;
      first_edge_r <= 1'b0;
      load_pend_r  <= 1'b0;
      miso_oe      <= 1'b0;
      busy         <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      tx_req       <= 1'b0;
`ifdef SPI_BRIDGE_SYNC_FRAME_ERR_EN
      frame_err    <= 1'b0;
      err_cnt      <= 8'd0;
`endif
    end else begin
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
`ifdef SPI_BRIDGE_SYNC_FRAME_ERR_EN
      frame_err <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
          if (cs_fall_s) begin
            state_r      <= ACTIVE;
            tx_req       <= 1'b1;
            load_pend_r  <= 1'b1;
            bit_cnt_r    <= '0;
            first_edge_r <= CPHA_B;
            miso_oe      <= 1'b1;
            busy         <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        ACTIVE: begin
          if (cs_rise_s) begin
            state_r      <= IDLE;
            bit_cnt_r    <= '0;
            tx_shift_r   <= '0;
            first_edge_r <= 1'b0;
            load_pend_r  <= 1'b0;
            miso_oe      <= 1'b0;
            busy         <= 1'b0;
`ifdef SPI_BRIDGE_SYNC_FRAME_ERR_EN
            if (bit_cnt_r != '0) begin
              frame_err <= 1'b1;
              if (err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
              end else begin
                err_cnt <= err_cnt;
              end
            end else begin
              frame_err <= 1'b0;
            end
`endif
          end else begin
            if (load_pend_r) begin
              tx_shift_r  <= tx_data;
              load_pend_r <= 1'b0;
            end else if (shift_s) begin
              if (first_edge_r) begin
                first_edge_r <= 1'b0;
              end else begin
                tx_shift_r <= {tx_shift_r[DATA_W-2:0], 1'b0};
              end
            end else begin
              tx_shift_r <= tx_shift_r;
            end
            if (sample_s) begin
              rx_shift_r <= {rx_shift_r[DATA_W-3:0], mosi_s};
              if (bit_cnt_r == CNT_LAST) begin
                bit_cnt_r    <= '0;
                rx_data      <= {rx_shift_r, mosi_s};
                rx_valid     <= 1'b1;
                tx_req       <= 1'b1;
                load_pend_r  <= 1'b1;
                first_edge_r <= 1'b1;
              end else begin
                bit_cnt_r <= bit_cnt_r + CNT_ONE;
              end
            end else begin
              rx_shift_r <= rx_shift_r;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_bridge_sync.sv
// Bench for spi_bridge_sync: three instances (mode 0 8-bit, mode 3 8-bit, mode 0 16-bit)
// driven by a bit-level SPI master model; expected words come from the master's own data.
module tb_spi_bridge_sync;

  localparam int HALF = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]  sclk_v = 3'b010;
  logic [2:0]  cs_v   = 3'b111;
  logic [2:0]  mosi_v = 3'b000;
  logic [2:0]  miso_v, miso_oe_v, rx_valid_v, tx_req_v, busy_v;
  logic [7:0]  rx_data0, rx_data1;
  logic [15:0] rx_data2;
  logic [7:0]  tx_data0 = 8'h00;
  logic [7:0]  tx_data1 = 8'h00;
  logic [15:0] tx_data2 = 16'h0000;
`ifdef SPI_BRIDGE_SYNC_FRAME_ERR_EN
  logic [2:0]  frame_err_v;
  logic [7:0]  err_cnt0, err_cnt1, err_cnt2;
  int          fe_cnt0 = 0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rxq0[$], rxq1[$], rxq2[$];
  logic [31:0] txq0[$], txq1[$], txq2[$];
  logic [31:0] mon_tmp;
  logic [7:0]  exp_last0 = 8'h00;

  spi_bridge_sync #(.DATA_W(8), .CPOL(0), .CPHA(0), .SYNC_STAGES(2)) u0 (
    .clk(clk), .rst(rst), .sclk(sclk_v[0]), .cs_n(cs_v[0]), .mosi(mosi_v[0]),
    .miso(miso_v[0]), .miso_oe(miso_oe_v[0]), .rx_data(rx_data0), .rx_valid(rx_valid_v[0]),
    .tx_req(tx_req_v[0]), .tx_data(tx_data0),
`ifdef SPI_BRIDGE_SYNC_FRAME_ERR_EN
    .frame_err(frame_err_v[0]), .err_cnt(err_cnt0),
`endif
    .busy(busy_v[0]));

  spi_bridge_sync #(.DATA_W(8), .CPOL(1), .CPHA(1), .SYNC_STAGES(3)) u1 (
    .clk(clk), .rst(rst), .sclk(sclk_v[1]), .cs_n(cs_v[1]), .mosi(mosi_v[1]),
    .miso(miso_v[1]), .miso_oe(miso_oe_v[1]), .rx_data(rx_data1), .rx_valid(rx_valid_v[1]),
    .tx_req(tx_req_v[1]), .tx_data(tx_data1),
`ifdef SPI_BRIDGE_SYNC_FRAME_ERR_EN
    .frame_err(frame_err_v[1]), .err_cnt(err_cnt1),
`endif
    .busy(busy_v[1]));

  spi_bridge_sync #(.DATA_W(16), .CPOL(0), .CPHA(0), .SYNC_STAGES(2)) u2 (
    .clk(clk), .rst(rst), .sclk(sclk_v[2]), .cs_n(cs_v[2]), .mosi(mosi_v[2]),
    .miso(miso_v[2]), .miso_oe(miso_oe_v[2]), .rx_data(rx_data2), .rx_valid(rx_valid_v[2]),
    .tx_req(tx_req_v[2]), .tx_data(tx_data2),
`ifdef SPI_BRIDGE_SYNC_FRAME_ERR_EN
    .frame_err(frame_err_v[2]), .err_cnt(err_cnt2),
`endif
    .busy(busy_v[2]));

  // Register-side model: record every rx_valid word, answer every tx_req from the tx queue
  always @(negedge clk) begin
    if (rx_valid_v[0]) rxq0.push_back({24'h0, rx_data0});
    if (rx_valid_v[1]) rxq1.push_back({24'h0, rx_data1});
    if (rx_valid_v[2]) rxq2.push_back({16'h0, rx_data2});
    if (tx_req_v[0]) begin
      mon_tmp = 32'h0;
      if (txq0.size() > 0) mon_tmp = txq0.pop_front();
      tx_data0 = mon_tmp[7:0];
    end
    if (tx_req_v[1]) begin
      mon_tmp = 32'h0;
      if (txq1.size() > 0) mon_tmp = txq1.pop_front();
      tx_data1 = mon_tmp[7:0];
    end
    if (tx_req_v[2]) begin
      mon_tmp = 32'h0;
      if (txq2.size() > 0) mon_tmp = txq2.pop_front();
      tx_data2 = mon_tmp[15:0];
    end
`ifdef SPI_BRIDGE_SYNC_FRAME_ERR_EN
    if (frame_err_v[0]) fe_cnt0++;
`endif
  end

  function automatic logic mode3(input int s);
    return (s == 1);
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_begin(input int s);
    sclk_v[s] = mode3(s);
    cs_v[s]   = 1'b0;
    wait_clk(2 * HALF);
  endtask

  task automatic cs_end(input int s);
    wait_clk(HALF);
    cs_v[s]   = 1'b1;
    mosi_v[s] = 1'b0;
    wait_clk(2 * HALF);
  endtask

  // One SPI bit as the master sees it: m is miso at the master's sample edge
  task automatic send_bit(input int s, input logic b, output logic m);
    if (mode3(s)) begin
      sclk_v[s] = ~sclk_v[s];
      mosi_v[s] = b;
      wait_clk(HALF);
      sclk_v[s] = ~sclk_v[s];
      m = miso_v[s];
      wait_clk(HALF);
    end else begin
      mosi_v[s] = b;
      wait_clk(HALF);
      sclk_v[s] = ~sclk_v[s];
      m = miso_v[s];
      wait_clk(HALF);
      sclk_v[s] = ~sclk_v[s];
    end
  endtask

  task automatic xfer(input int s, input int nbits, input logic [63:0] mo, output logic [63:0] mi);
    logic b;
    mi = '0;
    cs_begin(s);
    for (int i = nbits - 1; i >= 0; i--) begin
      send_bit(s, mo[i], b);
      mi[i] = b;
    end
    cs_end(s);
  endtask

  task automatic test_reset();
    wait_clk(3);
    n_checks++; if (miso_v !== 3'b000) begin n_fail++; $display("FAIL reset_miso: got %b expected 000", miso_v); end
    n_checks++; if (miso_oe_v !== 3'b000) begin n_fail++; $display("FAIL reset_miso_oe: got %b expected 000", miso_oe_v); end
    n_checks++; if (rx_valid_v !== 3'b000) begin n_fail++; $display("FAIL reset_rx_valid: got %b expected 000", rx_valid_v); end
    n_checks++; if (tx_req_v !== 3'b000) begin n_fail++; $display("FAIL reset_tx_req: got %b expected 000", tx_req_v); end
    n_checks++; if (busy_v !== 3'b000) begin n_fail++; $display("FAIL reset_busy: got %b expected 000", busy_v); end
    n_checks++; if ({rx_data0, rx_data1, rx_data2} !== 32'h0) begin n_fail++; $display("FAIL reset_rx_data: got %h %h %h expected 0", rx_data0, rx_data1, rx_data2); end
`ifdef SPI_BRIDGE_SYNC_FRAME_ERR_EN
    n_checks++; if ({frame_err_v, err_cnt0} !== 11'h0) begin n_fail++; $display("FAIL reset_err: got %b %h expected 0", frame_err_v, err_cnt0); end
`endif
    rst = 1'b0;
    wait_clk(6);
  endtask

  task automatic test_mode0_basic();
    logic [63:0] mi;
    logic [31:0] got;
    logic [7:0]  rw, tw;
    logic        b;
    rxq0.delete(); txq0.delete();
    txq0.push_back(32'h3C);
    mi = '0;
    cs_begin(0);
    n_checks++; if ({busy_v[0], miso_oe_v[0]} !== 2'b11) begin n_fail++; $display("FAIL m0_busy_active: got %b expected 11", {busy_v[0], miso_oe_v[0]}); end
    for (int i = 7; i >= 0; i--) begin
      send_bit(0, 1'(8'hA5 >> i), b);
      mi[i] = b;
    end
    cs_end(0);
    n_checks++; if (rxq0.size() !== 1) begin n_fail++; $display("FAIL m0_rx_count: got %0d expected 1", rxq0.size()); end
    got = 'x; if (rxq0.size() > 0) got = rxq0.pop_front();
    n_checks++; if (got !== 32'hA5) begin n_fail++; $display("FAIL m0_rx_data: got %h expected a5", got); end
    n_checks++; if (mi[7:0] !== 8'h3C) begin n_fail++; $display("FAIL m0_miso: got %h expected 3c", mi[7:0]); end
    n_checks++; if ({busy_v[0], miso_oe_v[0], miso_v[0]} !== 3'b000) begin n_fail++; $display("FAIL m0_idle: got %b expected 000", {busy_v[0], miso_oe_v[0], miso_v[0]}); end
    for (int k = 0; k < 4; k++) begin
      rw = 8'($urandom); tw = 8'($urandom);
      txq0.delete(); rxq0.delete();
      txq0.push_back({24'h0, tw});
      xfer(0, 8, {56'h0, rw}, mi);
      got = 'x; if (rxq0.size() == 1) got = rxq0.pop_front();
      n_checks++; if (got !== {24'h0, rw}) begin n_fail++; $display("FAIL m0_rand_rx: got %h expected %h", got, rw); end
      n_checks++; if (mi[7:0] !== tw) begin n_fail++; $display("FAIL m0_rand_miso: got %h expected %h", mi[7:0], tw); end
      n_checks++; if (rx_data0 !== rw) begin n_fail++; $display("FAIL m0_rand_hold: got %h expected %h", rx_data0, rw); end
      exp_last0 = rw;
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] mi;
    logic [31:0] got;
    logic [7:0]  rw[3];
    logic [7:0]  tw[3];
    rxq1.delete(); txq1.delete();
    txq1.push_back(32'h96); txq1.push_back(32'h81);
    xfer(1, 16, {48'h0, 8'h12, 8'hF0}, mi);
    n_checks++; if (rxq1.size() !== 2) begin n_fail++; $display("FAIL b2b_rx_count: got %0d expected 2", rxq1.size()); end
    got = 'x; if (rxq1.size() > 0) got = rxq1.pop_front();
    n_checks++; if (got !== 32'h12) begin n_fail++; $display("FAIL b2b_rx_first: got %h expected 12", got); end
    got = 'x; if (rxq1.size() > 0) got = rxq1.pop_front();
    n_checks++; if (got !== 32'hF0) begin n_fail++; $display("FAIL b2b_rx_second: got %h expected f0", got); end
    n_checks++; if (mi[15:0] !== 16'h9681) begin n_fail++; $display("FAIL b2b_miso: got %h expected 9681", mi[15:0]); end
    for (int k = 0; k < 3; k++) begin
      rxq1.delete(); txq1.delete();
      for (int j = 0; j < 3; j++) begin
        rw[j] = 8'($urandom); tw[j] = 8'($urandom);
        txq1.push_back({24'h0, tw[j]});
      end
      xfer(1, 24, {40'h0, rw[0], rw[1], rw[2]}, mi);
      n_checks++; if (rxq1.size() !== 3) begin n_fail++; $display("FAIL b2b_rand_count: got %0d expected 3", rxq1.size()); end
      for (int j = 0; j < 3; j++) begin
        got = 'x; if (rxq1.size() > 0) got = rxq1.pop_front();
        n_checks++; if (got !== {24'h0, rw[j]}) begin n_fail++; $display("FAIL b2b_rand_rx: word %0d got %h expected %h", j, got, rw[j]); end
      end
      n_checks++; if (mi[23:0] !== {tw[0], tw[1], tw[2]}) begin n_fail++; $display("FAIL b2b_rand_miso: got %h expected %h", mi[23:0], {tw[0], tw[1], tw[2]}); end
    end
  endtask

  task automatic test_wide();
    logic [63:0] mi;
    logic [31:0] got;
    logic [15:0] rw, tw;
    logic        b;
    for (int k = 0; k < 3; k++) begin
      rw = (k == 0) ? 16'hBEEF : 16'($urandom);
      tw = 16'($urandom);
      rxq2.delete(); txq2.delete();
      txq2.push_back({16'h0, tw});
      mi = '0;
      cs_begin(2);
      for (int i = 15; i >= 0; i--) begin
        send_bit(2, rw[i], b);
        mi[i] = b;
        if (i == 8) begin
          wait_clk(HALF);
          n_checks++; if (rxq2.size() !== 0) begin n_fail++; $display("FAIL wide_half_word: got %0d rx_valid expected 0", rxq2.size()); end
        end
      end
      cs_end(2);
      n_checks++; if (rxq2.size() !== 1) begin n_fail++; $display("FAIL wide_rx_count: got %0d expected 1", rxq2.size()); end
      got = 'x; if (rxq2.size() > 0) got = rxq2.pop_front();
      n_checks++; if (got !== {16'h0, rw}) begin n_fail++; $display("FAIL wide_rx: got %h expected %h", got, rw); end
      n_checks++; if (mi[15:0] !== tw) begin n_fail++; $display("FAIL wide_miso: got %h expected %h", mi[15:0], tw); end
    end
  endtask

  task automatic test_abort();
    logic [63:0] mi;
    rxq0.delete(); txq0.delete();
    txq0.push_back(32'h77);
    xfer(0, 5, 64'h1F, mi);
    n_checks++; if (rxq0.size() !== 0) begin n_fail++; $display("FAIL abort_rx_valid: got %0d expected 0", rxq0.size()); end
    n_checks++; if (rx_data0 !== exp_last0) begin n_fail++; $display("FAIL abort_rx_hold: got %h expected %h", rx_data0, exp_last0); end
    n_checks++; if ({miso_oe_v[0], busy_v[0]} !== 2'b00) begin n_fail++; $display("FAIL abort_oe: got %b expected 00", {miso_oe_v[0], busy_v[0]}); end
`ifdef SPI_BRIDGE_SYNC_FRAME_ERR_EN
    n_checks++; if (fe_cnt0 !== 1) begin n_fail++; $display("FAIL abort_frame_err: got %0d pulses expected 1", fe_cnt0); end
    n_checks++; if (err_cnt0 !== 8'd1) begin n_fail++; $display("FAIL abort_err_cnt: got %0d expected 1", err_cnt0); end
`endif
  endtask

  task automatic test_cs_rise_vs_sample();
    logic b;
    rxq0.delete(); txq0.delete();
    cs_begin(0);
    for (int i = 7; i >= 1; i--) send_bit(0, 1'(8'hC3 >> i), b);
    mosi_v[0] = 1'b1;
    wait_clk(HALF);
    sclk_v[0] = 1'b1;
    cs_v[0]   = 1'b1;
    wait_clk(2 * HALF);
    sclk_v[0] = 1'b0;
    wait_clk(2 * HALF);
    n_checks++; if (rxq0.size() !== 0) begin n_fail++; $display("FAIL simul_rx_valid: got %0d expected 0", rxq0.size()); end
    n_checks++; if (rx_data0 !== exp_last0) begin n_fail++; $display("FAIL simul_rx_hold: got %h expected %h", rx_data0, exp_last0); end
`ifdef SPI_BRIDGE_SYNC_FRAME_ERR_EN
    n_checks++; if (err_cnt0 !== 8'd2) begin n_fail++; $display("FAIL simul_err_cnt: got %0d expected 2", err_cnt0); end
`endif
  endtask

  task automatic test_reset_midword();
    logic [63:0] mi;
    logic [31:0] got;
    logic        b;
    rxq0.delete(); txq0.delete();
    txq0.push_back(32'hE7);
    cs_begin(0);
    for (int i = 7; i >= 5; i--) send_bit(0, 1'(8'hFF >> i), b);
    rst = 1'b1;
    #1;
    n_checks++; if ({miso_v[0], miso_oe_v[0], busy_v[0], rx_valid_v[0], tx_req_v[0]} !== 5'b0) begin n_fail++; $display("FAIL midrst_flags: got %b expected 00000", {miso_v[0], miso_oe_v[0], busy_v[0], rx_valid_v[0], tx_req_v[0]}); end
    n_checks++; if (rx_data0 !== 8'h00) begin n_fail++; $display("FAIL midrst_rx_data: got %h expected 00", rx_data0); end
`ifdef SPI_BRIDGE_SYNC_FRAME_ERR_EN
    n_checks++; if (err_cnt0 !== 8'd0) begin n_fail++; $display("FAIL midrst_err_cnt: got %0d expected 0", err_cnt0); end
`endif
    cs_v[0] = 1'b1; sclk_v[0] = 1'b0; mosi_v[0] = 1'b0;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(6);
    rxq0.delete(); txq0.delete();
    txq0.push_back(32'h4B);
    xfer(0, 8, 64'h5A, mi);
    n_checks++; if (rxq0.size() !== 1) begin n_fail++; $display("FAIL midrst_rx_count: got %0d expected 1", rxq0.size()); end
    got = 'x; if (rxq0.size() > 0) got = rxq0.pop_front();
    n_checks++; if (got !== 32'h5A) begin n_fail++; $display("FAIL midrst_rx: got %h expected 5a", got); end
    n_checks++; if (mi[7:0] !== 8'h4B) begin n_fail++; $display("FAIL midrst_miso: got %h expected 4b", mi[7:0]); end
  endtask

  initial begin
    test_reset();
    test_mode0_basic();
    test_back_to_back();
    test_wide();
    test_abort();
    test_cs_rise_vs_sample();
    test_reset_midword();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
